// File: rtl/tmds_channel_decoder_pkg.sv
// rtl/tmds_channel_decoder_pkg.sv - shared TMDS control tokens, FSM encoding and helpers
package tmds_channel_decoder_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Bit offsets cycle through 0..9 within the two-word window.
  function automatic logic [3:0] next_offset(input logic [3:0] cur);
    return (cur == 4'd9) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/tmds_decode_word.sv
// rtl/tmds_decode_word.sv - combinational decode of one aligned 10-bit TMDS word
module tmds_decode_word
  import tmds_channel_decoder_pkg::*;
(
  input  logic [9:0] word,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] q;

  assign q = word[9] ? ~word[7:0] : word[7:0];

  // word[8] selects whether the transmitter chained with XOR or XNOR.
  always_comb begin
    data    = 8'd0;
    data[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    case (word)
      TOKEN_C00: ctrl = 2'b00;
      TOKEN_C01: ctrl = 2'b01;
      TOKEN_C10: ctrl = 2'b10;
      TOKEN_C11: ctrl = 2'b11;
      default:   is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - one TMDS RX channel: word alignment by control-token runs, then decode
module tmds_channel_decoder
  import tmds_channel_decoder_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       aligned,
  output logic [3:0] offset
);

  localparam int MAX_TMO = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
  localparam int TMO_W   = $clog2(MAX_TMO) + 1;
  localparam int RUN_W   = $clog2(CTRL_RUN) + 1;

  localparam logic [TMO_W-1:0] SEARCH_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] LOCK_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(CTRL_RUN);

  state_e           state_q, state_d;
  logic [9:0]       w_q, w_d;
  logic [9:0]       w_prev_q, w_prev_d;
  logic [3:0]       offset_q, offset_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             de_q, de_d;

  logic [19:0] pair;
  logic [9:0]  win;
  logic        dec_is_ctrl;
  logic [1:0]  dec_ctrl;
  logic [7:0]  dec_data;
  logic        run_done;
  logic        search_tmo;
  logic        lock_tmo;

  // Older word sits in the low half so bit order matches serial arrival.
  assign pair = {w_q, w_prev_q};
  assign win  = 10'(pair >> offset_q);

  tmds_decode_word u_decode (
    .word    (win),
    .is_ctrl (dec_is_ctrl),
    .ctrl    (dec_ctrl),
    .data    (dec_data)
  );

  assign run_done   = (run_cnt_q == RUN_FULL);
  assign search_tmo = (tmo_cnt_q == SEARCH_LAST);
  assign lock_tmo   = (tmo_cnt_q == LOCK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // A completed run always beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: if (run_done) state_d = ST_LOCKED;
      ST_LOCKED: if (!run_done && lock_tmo) state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    aligned = (state_q == ST_LOCKED);
  end

  always_comb begin
    w_d      = tmds_word;
    w_prev_d = w_q;
    offset_d = offset_q;

    if (!dec_is_ctrl) begin
      run_cnt_d = '0;
    end else if (!run_done) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end else begin
      run_cnt_d = run_cnt_q;
    end

    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    if (run_done || (state_d != state_q)) begin
      tmo_cnt_d = '0;
    end

    if ((state_q == ST_SEARCH) && !run_done && search_tmo) begin
      offset_d  = next_offset(offset_q);
      run_cnt_d = '0;
      tmo_cnt_d = '0;
    end
  end

  // Data holds across control periods and ctrl holds across video periods.
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    de_d   = !dec_is_ctrl;
    if (dec_is_ctrl) begin
      ctrl_d = dec_ctrl;
    end else begin
      data_d = dec_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q       <= '0;
      w_prev_q  <= '0;
      offset_q  <= '0;
      run_cnt_q <= '0;
      tmo_cnt_q <= '0;
      data_q    <= '0;
      ctrl_q    <= '0;
      de_q      <= 1'b0;
    end else begin
      w_q       <= w_d;
      w_prev_q  <= w_prev_d;
      offset_q  <= offset_d;
      run_cnt_q <= run_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      de_q      <= de_d;
    end
  end

  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign de     = de_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - scoreboard bench for the TMDS channel decoder
module tb_tmds_channel_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  localparam bit [4:0] M_D   = 5'b00001;
  localparam bit [4:0] M_C   = 5'b00010;
  localparam bit [4:0] M_DE  = 5'b00100;
  localparam bit [4:0] M_AL  = 5'b01000;
  localparam bit [4:0] M_OFF = 5'b10000;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] tmds_word;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       aligned;
  logic [3:0] offset;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .CTRL_RUN       (8),
    .SEARCH_TIMEOUT (64),
    .LOCK_TIMEOUT   (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tmds_word (tmds_word),
    .data      (data),
    .ctrl      (ctrl),
    .de        (de),
    .aligned   (aligned),
    .offset    (offset)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    bit [4:0]   m;
    logic [7:0] d;
    logic [1:0] c;
    logic       de;
    logic       al;
    logic [3:0] off;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  bit         done = 0;
  bit         finished = 0;
  logic [9:0] prev_w;
  logic [9:0] toks [4];

  task automatic push(input int t, input string n, input bit [4:0] m, input logic [7:0] d,
                      input logic [1:0] c, input logic de_v, input logic al_v, input logic [3:0] off_v);
    exp_t e;
    e.cyc = t; e.name = n; e.m = m; e.d = d; e.c = c; e.de = de_v; e.al = al_v; e.off = off_v;
    sbq.push_back(e);
  endtask

  task automatic e_ctl(input int t, input string n, input logic [1:0] c);
    push(t, n, M_C | M_DE, 8'h00, c, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic e_dat(input int t, input string n, input logic [7:0] d);
    push(t, n, M_D | M_DE, d, 2'b00, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic e_st(input int t, input string n, input logic al_v, input logic [3:0] off_v);
    push(t, n, M_AL | M_OFF, 8'h00, 2'b00, 1'b0, al_v, off_v);
  endtask

  task automatic put(input logic [9:0] w);
    tmds_word = w;
    @(posedge clk);
    #1;
  endtask

  // Feed word w as if the serial stream were delayed by 3 bits.
  task automatic put_sh(input logic [9:0] w);
    logic [9:0] raw;
    raw = {w[6:0], prev_w[9:7]};
    prev_w = w;
    put(raw);
  endtask

  function automatic logic [9:0] enc(input logic [7:0] d, input logic xm, input logic inv);
    logic [7:0] q;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xm ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
    return {inv, xm, (inv ? ~q : q)};
  endfunction

  task automatic check_item(input exp_t e);
    bit bad;
    bad = 0;
    if (e.m[0] && data    !== e.d)   bad = 1;
    if (e.m[1] && ctrl    !== e.c)   bad = 1;
    if (e.m[2] && de      !== e.de)  bad = 1;
    if (e.m[3] && aligned !== e.al)  bad = 1;
    if (e.m[4] && offset  !== e.off) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s cyc=%0d mask=%b: got data=%h ctrl=%0d de=%b aligned=%b offset=%0d, want data=%h ctrl=%0d de=%b aligned=%b offset=%0d",
               e.name, e.cyc, e.m, data, ctrl, de, aligned, offset, e.d, e.c, e.de, e.al, e.off);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        check_item(sbq[i]);
        sbq.delete(i);
      end
    end
    if (done && !finished) begin
      finished = 1;
      checks++;
      if (sbq.size() != 0) begin
        errors++;
        $display("FAIL sb_drain: pending=%0d want 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    int c0;
    int c1;
    int l;
    logic [7:0] bytes4 [4];
    toks[0] = T00; toks[1] = T01; toks[2] = T10; toks[3] = T11;
    bytes4[0] = 8'h00; bytes4[1] = 8'h55; bytes4[2] = 8'hA7; bytes4[3] = 8'hFF;
    reset = 1'b1;
    tmds_word = '0;
    prev_w = '0;

    // T1: reset state
    repeat (3) put(10'd0);
    push(cyc, "t1_reset", M_D | M_C | M_DE | M_AL | M_OFF, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);

    // T2: aligned token stream locks at offset 0
    reset = 1'b0;
    c0 = cyc;
    e_ctl(c0 + 5, "t2_ctrl", 2'b00);
    e_st(c0 + 10, "t2_prelock", 1'b0, 4'd0);
    e_st(c0 + 11, "t2_lock", 1'b1, 4'd0);
    repeat (16) put(T00);

    // T6: rotating tokens, then reset mid-run
    reset = 1'b1;
    put(T00);
    reset = 1'b0;
    c0 = cyc;
    e_st(c0 + 10, "t6_prelock", 1'b0, 4'd0);
    e_st(c0 + 11, "t6_lock", 1'b1, 4'd0);
    for (int k = 0; k < 20; k++) begin
      if (k <= 17) e_ctl(cyc + 3, "t6_rot", 2'(k % 4));
      put(toks[k % 4]);
    end
    e_st(cyc, "t6_pre_rst", 1'b1, 4'd0);
    reset = 1'b1;
    push(cyc + 1, "t6_mid_rst", M_D | M_C | M_DE | M_AL | M_OFF, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
    put(toks[0]);
    reset = 1'b0;
    c1 = cyc;
    e_st(c1 + 10, "t6_relock_pre", 1'b0, 4'd0);
    e_st(c1 + 11, "t6_relock", 1'b1, 4'd0);
    for (int k = 0; k < 14; k++) put(toks[k % 4]);

    // T7: 7-token run, a data word, then exactly 8 tokens
    reset = 1'b1;
    put(T00);
    reset = 1'b0;
    c0 = cyc;
    e_ctl(c0 + 9, "t7_run1_ctrl", 2'b11);
    push(c0 + 10, "t7_gap", M_D | M_C | M_DE, 8'h5A, 2'b11, 1'b1, 1'b0, 4'd0);
    push(c0 + 11, "t7_hold", M_D | M_C | M_DE, 8'h5A, 2'b00, 1'b0, 1'b0, 4'd0);
    e_st(c0 + 12, "t7_partial", 1'b0, 4'd0);
    e_st(c0 + 18, "t7_prelock", 1'b0, 4'd0);
    e_st(c0 + 19, "t7_lock", 1'b1, 4'd0);
    repeat (7) put(T11);
    put(enc(8'h5A, 1'b1, 1'b1));
    repeat (8) put(T00);
    repeat (4) put(enc(8'h33, 1'b1, 1'b0));

    // T3: stream delayed 3 bits, offset hunts 0..3
    reset = 1'b1;
    put(10'd0);
    reset = 1'b0;
    prev_w = '0;
    c0 = cyc;
    e_st(c0 + 63,  "t3_off0", 1'b0, 4'd0);
    e_st(c0 + 64,  "t3_off1", 1'b0, 4'd1);
    e_st(c0 + 127, "t3_off1_end", 1'b0, 4'd1);
    e_st(c0 + 128, "t3_off2", 1'b0, 4'd2);
    e_st(c0 + 192, "t3_off3", 1'b0, 4'd3);
    e_ctl(c0 + 195, "t3_tok", 2'b00);
    e_st(c0 + 200, "t3_prelock", 1'b0, 4'd3);
    e_st(c0 + 201, "t3_lock", 1'b1, 4'd3);
    repeat (210) put_sh(T00);

    // T4/T5: data at offset 3, then loss of lock with offset retained
    l = cyc - 1;
    e_st(l + 11,  "t4_locked", 1'b1, 4'd3);
    e_st(l + 67,  "t5_prefall", 1'b1, 4'd3);
    e_st(l + 68,  "t5_fall", 1'b0, 4'd3);
    e_st(l + 100, "t5_hold", 1'b0, 4'd3);
    for (int j = 0; j < 8; j++) begin
      e_dat(cyc + 3, "t4_data", bytes4[j / 2]);
      put_sh(enc(bytes4[j / 2], (j < 4), j[0]));
    end
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) e_dat(cyc + 3, "t5_data", 8'(i));
      put_sh(enc(8'(i), 1'b1, 1'b0));
    end

    repeat (6) put(10'd0);
    done = 1;
  end

endmodule
